// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: control and tick bundle for the fractional baud generator
interface baud_gen_frac_if #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic [INT_W-1:0]  dvsr_int;
  logic [FRAC_W-1:0] dvsr_frac;
  logic              load;
  logic              resync;
  logic              sample_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              cfg_pending;
  modport master (
    output en, dvsr_int, dvsr_frac, load, resync,
    input  sample_tick, mid_tick, bit_tick, cfg_pending
  );
  modport slave (
    input  en, dvsr_int, dvsr_frac, load, resync,
    output sample_tick, mid_tick, bit_tick, cfg_pending
  );
endinterface

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: oversample/mid/bit tick generator with shadowed divisor;
// fractional divisor logic is present only when BAUD_GEN_FRAC_EN is defined.
module baud_gen_frac #(
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 1,
  parameter int DEF_FRAC = 0
) (
  input logic           clk,
  input logic           rst_n,
  baud_gen_frac_if.slave bus
);
  localparam int SW = $clog2(OVS);
  logic [INT_W-1:0] cnt, active_int, shadow_int, sel_int, eff_int;
  logic [SW-1:0]    sidx;
  logic             pending, sample_q, mid_q, bit_q;
  logic             reload, direct, apply, carry;
  // A same-cycle load+resync reloads with the new inputs; otherwise a pending shadow wins
  always_comb begin
    sel_int = (bus.resync && bus.load) ? bus.dvsr_int : pending ? shadow_int : active_int;
    eff_int = (sel_int == '0) ? INT_W'(1) : sel_int;
    reload  = bus.en && cnt == '0 && !bus.resync;
    direct  = bus.load && (!bus.en || bus.resync);
    apply   = pending && (reload || bus.resync);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sidx       <= '0;
      active_int <= INT_W'(DEF_INT);
      shadow_int <= INT_W'(DEF_INT);
      pending    <= 1'b0;
      sample_q   <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      sample_q <= reload;
      mid_q    <= reload && sidx == SW'(OVS / 2 - 1);
      bit_q    <= reload && sidx == SW'(OVS - 1);
      if (bus.resync) begin
        cnt  <= eff_int - INT_W'(1);
        sidx <= '0;
      end else if (reload) begin
        cnt  <= eff_int - INT_W'(1) + INT_W'(carry);
        sidx <= (sidx == SW'(OVS - 1)) ? '0 : sidx + SW'(1);
      end else if (bus.en) begin
        cnt <= cnt - INT_W'(1);
      end
      if (bus.load) shadow_int <= bus.dvsr_int;
      if (direct) active_int <= bus.dvsr_int;
      else if (apply) active_int <= shadow_int;
      pending <= direct ? 1'b0 : bus.load ? 1'b1 : apply ? 1'b0 : pending;
    end
  end
`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc, acc_nxt, active_frac, shadow_frac, sel_frac;
  // A zero integer divisor behaves as 1 with the fraction ignored
  always_comb begin
    sel_frac         = (bus.resync && bus.load) ? bus.dvsr_frac : pending ? shadow_frac : active_frac;
    {carry, acc_nxt} = {1'b0, acc} + {1'b0, (sel_int == '0) ? FRAC_W'(0) : sel_frac};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      active_frac <= FRAC_W'(DEF_FRAC);
      shadow_frac <= FRAC_W'(DEF_FRAC);
    end else begin
      if (bus.resync) acc <= '0;
      else if (reload) acc <= acc_nxt;
      if (bus.load) shadow_frac <= bus.dvsr_frac;
      if (direct) active_frac <= bus.dvsr_frac;
      else if (apply) active_frac <= shadow_frac;
    end
  end
`else
  assign carry = 1'b0;
`endif
  assign bus.sample_tick = sample_q;
  assign bus.mid_tick    = mid_q;
  assign bus.bit_tick    = bit_q;
  assign bus.cfg_pending = pending;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: table-driven divisor vectors plus directed load/resync/en/reset sequences
module tb_baud_gen_frac;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  typedef struct {
    int ival;
    int fval;
    int lat;
    int span_f;
    int span_n;
  } vec_t;
  vec_t vecs[6];
  baud_gen_frac_if #(.INT_W(16), .FRAC_W(4)) bus ();
  baud_gen_frac #(.INT_W(16), .FRAC_W(4), .OVS(16), .DEF_INT(1), .DEF_FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic setup(input int iv, input int fv);
    @(negedge clk);
    bus.en = 1'b0; bus.load = 1'b1; bus.resync = 1'b1;
    bus.dvsr_int = 16'(iv); bus.dvsr_frac = 4'(fv);
    @(negedge clk);
    bus.load = 1'b0; bus.resync = 1'b0; bus.en = 1'b1;
  endtask
  task automatic wait_on(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 300 && n < 0; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.sample_tick) || (which == 1 && bus.mid_tick) ||
          (which == 2 && bus.bit_tick)) n = i;
    end
  endtask
  initial begin
    int n, ticks, t1, t17, mid_idx, bit_idx, seen;
    vecs[0] = '{4, 0, 4, 64, 64};
    vecs[1] = '{3, 8, 3, 56, 48};
    vecs[2] = '{5, 4, 5, 84, 80};
    vecs[3] = '{2, 15, 2, 47, 32};
    vecs[4] = '{0, 5, 1, 16, 16};
    vecs[5] = '{1, 0, 1, 16, 16};
    rst_n = 1'b0;
    bus.en = 1'b1; bus.load = 1'b0; bus.resync = 1'b0;
    bus.dvsr_int = '0; bus.dvsr_frac = '0;
    repeat (2) @(negedge clk);
    chk("rst_sample", int'(bus.sample_tick), 0);
    chk("rst_mid", int'(bus.mid_tick), 0);
    chk("rst_bit", int'(bus.bit_tick), 0);
    chk("rst_pending", int'(bus.cfg_pending), 0);
    rst_n = 1'b1;
    wait_on(0, n);
    chk("first_tick_after_rst", n, 1);
    wait_on(0, n);
    chk("def_period", n, 1);
    // Table: resync-load each divisor, then time 16 full periods and tick positions
    for (int k = 0; k < 6; k++) begin
      setup(vecs[k].ival, vecs[k].fval);
      ticks = 0; t1 = -1; t17 = -1; mid_idx = -1; bit_idx = -1;
      for (int i = 1; i <= 400 && ticks < 17; i++) begin
        @(negedge clk);
        if (bus.sample_tick) begin
          ticks++;
          if (ticks == 1) t1 = i;
          if (ticks == 17) t17 = i;
        end
        if (bus.mid_tick && mid_idx < 0) mid_idx = ticks;
        if (bus.bit_tick && bit_idx < 0) bit_idx = ticks;
      end
      chk($sformatf("v%0d_latency", k), t1, vecs[k].lat);
      chk($sformatf("v%0d_span16", k), (t17 < 0) ? -1 : t17 - t1,
          FRAC_ON ? vecs[k].span_f : vecs[k].span_n);
      chk($sformatf("v%0d_mid_idx", k), mid_idx, 8);
      chk($sformatf("v%0d_bit_idx", k), bit_idx, 16);
    end
    // Shadow load two cycles after a tick applies at the next tick
    setup(4, 0);
    wait_on(0, n);
    chk("seq_load_lat", n, 4);
    repeat (2) @(negedge clk);
    bus.load = 1'b1; bus.dvsr_int = 16'd8;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pending_set", int'(bus.cfg_pending), 1);
    @(negedge clk);
    chk("pending_tick", int'(bus.sample_tick), 1);
    chk("pending_clr", int'(bus.cfg_pending), 0);
    wait_on(0, n);
    chk("new_period", n, 8);
    // Resync landing on a reload edge at sidx 5
    setup(4, 0);
    repeat (5) wait_on(0, n);
    repeat (3) @(negedge clk);
    bus.resync = 1'b1;
    @(negedge clk);
    bus.resync = 1'b0;
    chk("resync_no_tick", int'(bus.sample_tick), 0);
    wait_on(1, n);
    chk("resync_mid", n, 32);
    wait_on(2, n);
    chk("resync_bit_after_mid", n, 32);
    // Freeze for 10 edges mid-period, with an immediate load while frozen
    setup(4, 0);
    wait_on(0, n);
    @(negedge clk);
    bus.en = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen += int'(bus.sample_tick) + int'(bus.mid_tick) + int'(bus.bit_tick);
      if (i == 3) chk("load_while_off_pending", int'(bus.cfg_pending), 0);
      bus.load = (i == 2);
      bus.dvsr_int = 16'd6;
    end
    chk("freeze_quiet", seen, 0);
    bus.en = 1'b1;
    wait_on(0, n);
    chk("resume_remaining", n, 3);
    wait_on(0, n);
    chk("resume_period", n, 6);
    // Async reset with a pending divisor returns to the default divisor
    wait_on(0, n);
    @(negedge clk);
    bus.load = 1'b1; bus.dvsr_int = 16'd9;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pre_rst_pending", int'(bus.cfg_pending), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pending", int'(bus.cfg_pending), 0);
    chk("async_rst_sample", int'(bus.sample_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_on(0, n);
    chk("post_rst_first", n, 1);
    wait_on(0, n);
    chk("post_rst_def_period", n, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
